nw_trace_reader: RTL and testbench

NW_TRACE_READER -- requirements
Module: nw_trace_reader

---
 rtl/nw_pkg.sv | 30 +++
 rtl/nw_step_decode.sv | 36 +++
 rtl/nw_trace_reader.sv | 226 ++++++++++++++++++++++
 tb/tb_nw_trace_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nw_pkg
//  Description : Shared encodings for the NW traceback reader: traceback
//                directions, step classes and reader FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package nw_pkg;

    localparam logic [1:0] c_TOP_DIR    = 2'd1;
    localparam logic [1:0] c_LEFT_DIR   = 2'd2;
    localparam logic [1:0] c_CORNER_DIR = 2'd3;

    // Step classes reuse the direction codes of the grid that produced them.
    localparam logic [1:0] c_STEP_BAD  = 2'd0;
    localparam logic [1:0] c_STEP_UP   = c_TOP_DIR;
    localparam logic [1:0] c_STEP_LEFT = c_LEFT_DIR;
    localparam logic [1:0] c_STEP_DIAG = c_CORNER_DIR;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RD_CUR  = 3'd1;
    localparam logic [2:0] c_ST_LAT_CUR = 3'd2;
    localparam logic [2:0] c_ST_RD_NXT  = 3'd3;
    localparam logic [2:0] c_ST_LAT_NXT = 3'd4;
    localparam logic [2:0] c_ST_EMIT    = 3'd5;
    localparam logic [2:0] c_ST_DONE    = 3'd6;
    localparam logic [2:0] c_ST_ERR     = 3'd7;

endpackage
`default_nettype wire

// File: rtl/nw_step_decode.sv
`default_nettype none
// ============================================================================
//  Module      : nw_step_decode
//  Description : Classifies one traceback step {x,y} -> {x,y} as diagonal,
//                up, left or illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module nw_step_decode
    import nw_pkg::*;
#(
    parameter int CORD_LENGTH = 8
) (
    input  logic [2*CORD_LENGTH-1:0] i_cur,
    input  logic [2*CORD_LENGTH-1:0] i_nxt,
    output logic [1:0]               o_step
);

    logic [CORD_LENGTH:0] w_dx;
    logic [CORD_LENGTH:0] w_dy;

    // One extra bit so a coordinate that grows wraps to a large value.
    assign w_dx = {1'b0, i_cur[2*CORD_LENGTH-1:CORD_LENGTH]} - {1'b0, i_nxt[2*CORD_LENGTH-1:CORD_LENGTH]};
    assign w_dy = {1'b0, i_cur[CORD_LENGTH-1:0]} - {1'b0, i_nxt[CORD_LENGTH-1:0]};

    always_comb begin
        o_step = c_STEP_BAD;
        if (w_dx == (CORD_LENGTH+1)'(1) && w_dy == (CORD_LENGTH+1)'(1))
            o_step = c_STEP_DIAG;
        else if (w_dx == '0 && w_dy == (CORD_LENGTH+1)'(1))
            o_step = c_STEP_UP;
        else if (w_dx == (CORD_LENGTH+1)'(1) && w_dy == '0)
            o_step = c_STEP_LEFT;
    end

endmodule
`default_nettype wire

// File: rtl/nw_trace_reader.sv
`default_nettype none
// ============================================================================
//  Module      : nw_trace_reader
//  Description : Walks the NW traceback path in trace memory and streams the
//                aligned columns (end of strings first) over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module nw_trace_reader
    import nw_pkg::*;
#(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int CORD_LENGTH = 8,
    parameter int MEM_SIZE    = 9,
    parameter int BYTE_SIZE   = 2*CORD_LENGTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    output logic                     ren,
    output logic [MEM_SIZE-1:0]      raddr,
    input  logic [BYTE_SIZE-1:0]     rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CWIDTH-1:0]        out_c1,
    output logic [CWIDTH-1:0]        out_c2,
    output logic                     out_gap1,
    output logic                     out_gap2,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);

    localparam logic [BYTE_SIZE-1:0] c_FIRST_ENTRY = {CORD_LENGTH'(LENGTH-1), CORD_LENGTH'(LENGTH-1)};
    localparam logic [MEM_SIZE-1:0]  c_MAX_ADDR    = MEM_SIZE'(2*LENGTH-2);

    logic [2:0]           r_state;
    logic [2:0]           w_state_nxt;
    logic [BYTE_SIZE-1:0] r_cur;
    logic [BYTE_SIZE-1:0] r_nxt;
    logic [MEM_SIZE-1:0]  r_addr;
    logic                 r_error;
    logic [CWIDTH-1:0]    r_c1;
    logic [CWIDTH-1:0]    r_c2;
    logic                 r_gap1;
    logic                 r_gap2;
    logic                 r_last;
    logic [1:0]           w_step;

    nw_step_decode #(
        .CORD_LENGTH (CORD_LENGTH)
    ) u_step_decode (
        .i_cur  (r_cur),
        .i_nxt  (rdata),
        .o_step (w_step)
    );

    function automatic logic [CWIDTH-1:0] char_at(
        input logic [LENGTH*CWIDTH-1:0] s,
        input logic [CORD_LENGTH-1:0]   idx
    );
        char_at = '0;
        for (int j = 0; j < LENGTH; j++)
            if (idx == CORD_LENGTH'(j))
                char_at = s[(LENGTH-1-j)*CWIDTH +: CWIDTH];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= c_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        ren         = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                busy = 1'b0;
                if (start)
                    w_state_nxt = c_ST_RD_CUR;
            end
            c_ST_RD_CUR: begin
                ren         = 1'b1;
                w_state_nxt = c_ST_LAT_CUR;
            end
            c_ST_LAT_CUR: begin
                if (rdata != c_FIRST_ENTRY)
                    w_state_nxt = c_ST_ERR;
                else if (rdata == '0)
                    w_state_nxt = c_ST_EMIT;
                else
                    w_state_nxt = c_ST_RD_NXT;
            end
            c_ST_RD_NXT: begin
                ren         = 1'b1;
                w_state_nxt = c_ST_LAT_NXT;
            end
            c_ST_LAT_NXT: begin
                // r_addr is the index of the entry just read; the path may hold at most 2*LENGTH-1 entries.
                if (r_addr > c_MAX_ADDR || w_step == c_STEP_BAD)
                    w_state_nxt = c_ST_ERR;
                else
                    w_state_nxt = c_ST_EMIT;
            end
            c_ST_EMIT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_last)
                        w_state_nxt = c_ST_DONE;
                    else if (r_nxt == '0)
                        w_state_nxt = c_ST_EMIT;
                    else
                        w_state_nxt = c_ST_RD_NXT;
                end
            end
            c_ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            c_ST_ERR: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur   <= '0;
            r_nxt   <= '0;
            r_addr  <= '0;
            r_error <= 1'b0;
            r_c1    <= '0;
            r_c2    <= '0;
            r_gap1  <= 1'b0;
            r_gap2  <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_error <= 1'b0;
                        r_addr  <= '0;
                    end
                end
                c_ST_LAT_CUR: begin
                    r_cur <= rdata;
                    if (rdata == '0) begin
                        r_c1   <= char_at(s1, '0);
                        r_c2   <= char_at(s2, '0);
                        r_gap1 <= 1'b0;
                        r_gap2 <= 1'b0;
                        r_last <= 1'b1;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                c_ST_LAT_NXT: begin
                    r_nxt  <= rdata;
                    r_last <= 1'b0;
                    case (w_step)
                        c_STEP_DIAG: begin
                            r_c1   <= char_at(s1, r_cur[CORD_LENGTH-1:0]);
                            r_c2   <= char_at(s2, r_cur[BYTE_SIZE-1:CORD_LENGTH]);
                            r_gap1 <= 1'b0;
                            r_gap2 <= 1'b0;
                        end
                        c_STEP_UP: begin
                            r_c1   <= char_at(s1, r_cur[CORD_LENGTH-1:0]);
                            r_c2   <= '0;
                            r_gap1 <= 1'b0;
                            r_gap2 <= 1'b1;
                        end
                        c_STEP_LEFT: begin
                            r_c1   <= '0;
                            r_c2   <= char_at(s2, r_cur[BYTE_SIZE-1:CORD_LENGTH]);
                            r_gap1 <= 1'b1;
                            r_gap2 <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
                c_ST_EMIT: begin
                    if (out_ready && !r_last) begin
                        r_cur <= r_nxt;
                        if (r_nxt == '0) begin
                            r_c1   <= char_at(s1, '0);
                            r_c2   <= char_at(s2, '0);
                            r_gap1 <= 1'b0;
                            r_gap2 <= 1'b0;
                            r_last <= 1'b1;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                c_ST_ERR: begin
                    r_error <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign raddr    = r_addr;
    assign out_c1   = r_c1;
    assign out_c2   = r_c2;
    assign out_gap1 = r_gap1;
    assign out_gap2 = r_gap2;
    assign out_last = r_last;
    assign error    = r_error | (r_state == c_ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_nw_trace_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nw_trace_reader
//  Description : Directed self-checking bench for nw_trace_reader (LENGTH=4)
//                with a 1-cycle-latency trace memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nw_trace_reader;

    localparam int LENGTH      = 4;
    localparam int CWIDTH      = 2;
    localparam int CORD_LENGTH = 8;
    localparam int MEM_SIZE    = 9;
    localparam int BYTE_SIZE   = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic [LENGTH*CWIDTH-1:0] s1;
    logic [LENGTH*CWIDTH-1:0] s2;
    logic                     ren;
    logic [MEM_SIZE-1:0]      raddr;
    logic [BYTE_SIZE-1:0]     rdata = '0;
    logic                     out_valid;
    logic                     out_ready;
    logic [CWIDTH-1:0]        out_c1;
    logic [CWIDTH-1:0]        out_c2;
    logic                     out_gap1;
    logic                     out_gap2;
    logic                     out_last;
    logic                     busy;
    logic                     done;
    logic                     error;

    logic [BYTE_SIZE-1:0] mem [0:(1<<MEM_SIZE)-1];

    nw_trace_reader #(
        .LENGTH      (LENGTH),
        .CWIDTH      (CWIDTH),
        .CORD_LENGTH (CORD_LENGTH),
        .MEM_SIZE    (MEM_SIZE),
        .BYTE_SIZE   (BYTE_SIZE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .s1        (s1),
        .s2        (s2),
        .ren       (ren),
        .raddr     (raddr),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c1    (out_c1),
        .out_c2    (out_c2),
        .out_gap1  (out_gap1),
        .out_gap2  (out_gap2),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (ren) rdata <= mem[raddr];

    int         n_vec     = 0;
    int         n_miscmp  = 0;
    logic [6:0] cols [16];
    logic [6:0] hold_obs [8];
    int         ncol, ndone, nreads, err_cyc, n_hold, stall_left;
    logic       found;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] col(input int c1, input int c2, input int g1, input int g2, input int l);
        return {c1[1:0], c2[1:0], g1[0], g2[0], l[0]};
    endfunction

    function automatic logic [6:0] obs();
        return {out_c1, out_c2, out_gap1, out_gap2, out_last};
    endfunction

    task automatic set_entry(input int idx, input int x, input int y);
        mem[idx] = {x[7:0], y[7:0]};
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
    endtask

    // Runs one decode for a fixed cycle budget, accepting columns except for
    // 5 stall cycles on column index stall_col (-1 = never stall).
    task automatic run_decode(input int stall_col, input int cycles);
        ncol = 0; ndone = 0; nreads = 0; err_cyc = -1; n_hold = 0; stall_left = 5;
        @(negedge clk);
        start     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (ren) nreads++;
            if (done) ndone++;
            if (error && err_cyc < 0) err_cyc = c;
            if (out_valid) begin
                if (ncol == stall_col && stall_left > 0) begin
                    hold_obs[n_hold] = obs();
                    n_hold++;
                    stall_left--;
                    out_ready = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    if (ncol < 16) cols[ncol] = obs();
                    ncol++;
                end
            end else begin
                out_ready = 1'b1;
            end
        end
    endtask

    task automatic load_identical();
        clear_mem();
        s1 = 8'h1B;
        s2 = 8'h1B;
        set_entry(0, 3, 3);
        set_entry(1, 2, 2);
        set_entry(2, 1, 1);
        set_entry(3, 0, 0);
    endtask

    task automatic check_identical(input string pfx);
        check_val({pfx, "_ncol"},  ncol,   4);
        check_val({pfx, "_col0"},  cols[0], col(3, 3, 0, 0, 0));
        check_val({pfx, "_col1"},  cols[1], col(2, 2, 0, 0, 0));
        check_val({pfx, "_col2"},  cols[2], col(1, 1, 0, 0, 0));
        check_val({pfx, "_col3"},  cols[3], col(0, 0, 0, 0, 1));
        check_val({pfx, "_done"},  ndone,  1);
        check_val({pfx, "_reads"}, nreads, 4);
        check_val({pfx, "_err"},   error,  0);
        check_val({pfx, "_idle"},  busy,   0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        s1        = '0;
        s2        = '0;
        clear_mem();
        #12;
        check_val("reset_outputs",
                  {ren, raddr, out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last, busy, done, error}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Bad first entry (2,3): error quickly, no columns, error sticky
        clear_mem();
        s1 = 8'h1B; s2 = 8'h1B;
        set_entry(0, 2, 3);
        run_decode(-1, 12);
        check_val("badfirst_ncol", ncol, 0);
        check_val("badfirst_errtime", (err_cyc >= 0 && err_cyc <= 3), 1);
        check_val("badfirst_sticky", error, 1);
        check_val("badfirst_done", ndone, 0);

        // Identical strings; start also clears the sticky error
        load_identical();
        run_decode(-1, 30);
        check_identical("ident");

        // Gapped path with 5-cycle backpressure on the 2nd column
        clear_mem();
        s1 = 8'h1B;
        s2 = 8'hE4;
        set_entry(0, 3, 3);
        set_entry(1, 3, 2);
        set_entry(2, 2, 1);
        set_entry(3, 1, 0);
        set_entry(4, 0, 0);
        run_decode(1, 40);
        check_val("gap_ncol",  ncol, 5);
        check_val("gap_col0",  cols[0], col(3, 0, 0, 1, 0));
        check_val("gap_col1",  cols[1], col(2, 0, 0, 0, 0));
        check_val("gap_col2",  cols[2], col(1, 1, 0, 0, 0));
        check_val("gap_col3",  cols[3], col(0, 2, 1, 0, 0));
        check_val("gap_col4",  cols[4], col(0, 3, 0, 0, 1));
        check_val("gap_nhold", n_hold, 5);
        for (int i = 0; i < 5; i++)
            check_val($sformatf("gap_hold%0d", i), hold_obs[i], col(2, 0, 0, 0, 0));
        check_val("gap_reads", nreads, 5);
        check_val("gap_done",  ndone, 1);

        // Illegal step (2,2)->(0,2) after one good column
        clear_mem();
        s1 = 8'h1B; s2 = 8'h1B;
        set_entry(0, 3, 3);
        set_entry(1, 2, 2);
        set_entry(2, 0, 2);
        run_decode(-1, 20);
        check_val("badstep_ncol", ncol, 1);
        check_val("badstep_col0", cols[0], col(3, 3, 0, 0, 0));
        check_val("badstep_err",  error, 1);
        check_val("badstep_done", ndone, 0);

        // Coordinate that grows, (2,2)->(3,1), underflows dx and is illegal
        set_entry(2, 3, 1);
        run_decode(-1, 20);
        check_val("uflow_ncol", ncol, 1);
        check_val("uflow_err",  error, 1);

        // Asynchronous reset while a column is pending
        load_identical();
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b1;
        found     = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        check_val("rst_reach_emit", found, 1);
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_async_valid", out_valid, 0);
        check_val("rst_async_busy",  busy, 0);
        @(negedge clk);
        reset = 1'b0;
        run_decode(-1, 30);
        check_identical("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
`default_nettype wire
